nlc_channel_scheduler: RTL and testbench

- Time-shares one single-channel NLC core (21-bit x_adc in, 21-bit x_lin out, srdyi/srdyo strobes) among NUM_CH ADC channels.
- Buffers one sample per channel and issues samples to the core round-robin, no faster than the core initiation interval.
- Tracks the channel of each in-flight sample in a tag FIFO and routes each core result back to its originating channel.
- Sits between the ADC front-ends and the NLC core in the multi-channel top level.

---
 rtl/nlc_sched_pkg.sv | 19 +
 rtl/nlc_channel_scheduler_tag_fifo.sv | 65 ++++++
 rtl/nlc_channel_scheduler.sv | 188 ++++++++++++++++++
 tb/tb_nlc_channel_scheduler.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/nlc_sched_pkg.sv
// Shared constants for the NLC channel scheduler: default sizes, FSM encoding,
// and a saturating counter helper used by the optional statistics block.
package nlc_sched_pkg;

  localparam int NUM_CH_DEF    = 4;
  localparam int DATA_W_DEF    = 21;
  localparam int TAG_DEPTH_DEF = 8;
  localparam int CH_IDX_W      = $clog2(NUM_CH_DEF);
  localparam int TAG_PTR_W     = $clog2(TAG_DEPTH_DEF);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/nlc_channel_scheduler_tag_fifo.sv
// Tag FIFO holding the originating channel of every sample in flight in the core.
// Push and pop in the same cycle are accepted even when full.
module nlc_tag_fifo
  import nlc_sched_pkg::*;
#(
  parameter int TAG_W = CH_IDX_W,
  parameter int DEPTH = TAG_DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [TAG_W-1:0]       push_tag,
  input  logic                   pop,
  output logic [TAG_W-1:0]       pop_tag,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0][TAG_W-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]              count_q, count_d;
  logic                        push_ok, pop_ok;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign pop_tag = mem_q[rd_ptr_q];
  assign count   = count_q;

  // When full, wr_ptr == rd_ptr; the popped entry is read before it is overwritten.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_tag;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/nlc_channel_scheduler.sv
// Round-robin time-sharing of one NLC core among NUM_CH ADC channels, with result
// routing by tag. Optional per-channel statistics under NLC_SCHED_STATS_EN.
//   state | meaning
//   IDLE  | nothing issued; waiting for a pending sample and FIFO room
//   ISSUE | core_srdyi high this cycle; may issue again if ISSUE_GAP == 1
//   GAP   | gap counter running down before the next issue is allowed
module nlc_channel_scheduler
  import nlc_sched_pkg::*;
#(
  parameter int NUM_CH    = NUM_CH_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int TAG_DEPTH = TAG_DEPTH_DEF,
  parameter int ISSUE_GAP = 1
) (
  input  logic                       clk,
  input  logic                       GlobalReset,
  input  logic [NUM_CH-1:0]          ch_srdyi,
  input  logic [NUM_CH*DATA_W-1:0]   ch_x_adc,
  output logic [NUM_CH-1:0]          ch_srdyo,
  output logic [DATA_W-1:0]          ch_x_lin,
  output logic                       core_srdyi,
  output logic [DATA_W-1:0]          core_x_adc,
  input  logic                       core_srdyo,
  input  logic [DATA_W-1:0]          core_x_lin,
  output logic [NUM_CH-1:0]          ovf_sticky,
  output logic                       orphan_sticky,
`ifdef NLC_SCHED_STATS_EN
  output logic [NUM_CH*16-1:0]       stat_done_cnt,
  output logic [NUM_CH*16-1:0]       stat_drop_cnt,
`endif
  output logic [$clog2(TAG_DEPTH):0] in_flight
);
  localparam int CH_W  = $clog2(NUM_CH);
  localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(ISSUE_GAP - 1);

  logic [1:0]                     state_q, state_d;
  logic [CH_W-1:0]                ptr_q, ptr_d;
  logic [GAP_W-1:0]               gap_cnt_q, gap_cnt_d;
  logic [NUM_CH-1:0]              pending_q, pending_d;
  logic [NUM_CH-1:0][DATA_W-1:0]  hold_q, hold_d;
  logic                           core_srdyi_q, core_srdyi_d;
  logic [DATA_W-1:0]              core_x_adc_q, core_x_adc_d;
  logic [NUM_CH-1:0]              ch_srdyo_q, ch_srdyo_d;
  logic [DATA_W-1:0]              ch_x_lin_q, ch_x_lin_d;
  logic [NUM_CH-1:0]              ovf_q, ovf_d;
  logic                           orphan_q, orphan_d;

  logic [CH_W-1:0]   grant, pop_tag;
  logic [CH_W:0]     idx;
  logic              grant_vld, can_issue, pop, fifo_full, fifo_empty;
  logic [NUM_CH-1:0] drop;

  nlc_tag_fifo #(.TAG_W(CH_W), .DEPTH(TAG_DEPTH)) u_tag_fifo (
    .clk      (clk),
    .rst      (GlobalReset),
    .push     (can_issue),
    .push_tag (grant),
    .pop      (pop),
    .pop_tag  (pop_tag),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (in_flight)
  );

  // Scan from the farthest offset down so the nearest pending channel wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    idx       = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + (CH_W+1)'(k);
      if (idx >= (CH_W+1)'(NUM_CH)) idx = idx - (CH_W+1)'(NUM_CH);
      if (pending_q[idx[CH_W-1:0]]) begin
        grant     = idx[CH_W-1:0];
        grant_vld = 1'b1;
      end
    end
  end

  // The issue decision is registered, so the cycle spent in ISSUE is the core_srdyi cycle.
  assign pop       = core_srdyo && !fifo_empty;
  assign can_issue = (gap_cnt_q == '0) && grant_vld && (!fifo_full || pop);

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: if (can_issue) state_d = ST_ISSUE;
      ST_ISSUE, ST_GAP: begin
        if (gap_cnt_q != '0) begin
          state_d   = ST_GAP;
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end else begin
          state_d = can_issue ? ST_ISSUE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (can_issue) gap_cnt_d = GAP_LOAD;
  end

  always_comb begin
    pending_d    = pending_q;
    hold_d       = hold_q;
    drop         = '0;
    core_srdyi_d = can_issue;
    core_x_adc_d = can_issue ? hold_q[grant] : core_x_adc_q;
    ptr_d        = ptr_q;
    if (can_issue) begin
      pending_d[grant] = 1'b0;
      ptr_d = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_srdyi[i]) begin
        hold_d[i]    = ch_x_adc[i*DATA_W +: DATA_W];
        pending_d[i] = 1'b1;
        drop[i]      = pending_q[i] && !(can_issue && grant == CH_W'(i));
      end
    end
    ovf_d      = ovf_q | drop;
    ch_srdyo_d = pop ? (NUM_CH'(1) << pop_tag) : '0;
    ch_x_lin_d = pop ? core_x_lin : ch_x_lin_q;
    orphan_d   = orphan_q | (core_srdyo & fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state_q      <= ST_IDLE;
      ptr_q        <= '0;
      gap_cnt_q    <= '0;
      pending_q    <= '0;
      hold_q       <= '0;
      core_srdyi_q <= 1'b0;
      core_x_adc_q <= '0;
      ch_srdyo_q   <= '0;
      ch_x_lin_q   <= '0;
      ovf_q        <= '0;
      orphan_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gap_cnt_q    <= gap_cnt_d;
      pending_q    <= pending_d;
      hold_q       <= hold_d;
      core_srdyi_q <= core_srdyi_d;
      core_x_adc_q <= core_x_adc_d;
      ch_srdyo_q   <= ch_srdyo_d;
      ch_x_lin_q   <= ch_x_lin_d;
      ovf_q        <= ovf_d;
      orphan_q     <= orphan_d;
    end
  end

  assign core_srdyi    = core_srdyi_q;
  assign core_x_adc    = core_x_adc_q;
  assign ch_srdyo      = ch_srdyo_q;
  assign ch_x_lin      = ch_x_lin_q;
  assign ovf_sticky    = ovf_q;
  assign orphan_sticky = orphan_q;

`ifdef NLC_SCHED_STATS_EN
  logic [NUM_CH-1:0][15:0] done_q, done_d, drop_cnt_q, drop_cnt_d;

  always_comb begin
    done_d     = done_q;
    drop_cnt_d = drop_cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_srdyo_d[i]) done_d[i] = sat_inc16(done_q[i]);
      if (drop[i])       drop_cnt_d[i] = sat_inc16(drop_cnt_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      done_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      done_q     <= done_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign stat_done_cnt = done_q;
  assign stat_drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_nlc_channel_scheduler.sv
// Directed bench for nlc_channel_scheduler: one instance with ISSUE_GAP=1 and one
// with ISSUE_GAP=3; the core is modelled by directed core_srdyo pulses.
module tb_nlc_channel_scheduler;
  localparam int NCH = 4;
  localparam int DW  = 21;

  logic clk = 1'b0;
  logic GlobalReset;
  always #5 clk = ~clk;

  logic [NCH-1:0]    ch_srdyi, ch_srdyo, ovf_sticky;
  logic [NCH*DW-1:0] ch_x_adc;
  logic [DW-1:0]     ch_x_lin, core_x_adc, core_x_lin;
  logic              core_srdyi, core_srdyo, orphan_sticky;
  logic [3:0]        in_flight;

  logic [NCH-1:0]    g_ch_srdyi, g_ch_srdyo, g_ovf_sticky;
  logic [NCH*DW-1:0] g_ch_x_adc;
  logic [DW-1:0]     g_ch_x_lin, g_core_x_adc, g_core_x_lin;
  logic              g_core_srdyi, g_core_srdyo, g_orphan_sticky;
  logic [3:0]        g_in_flight;
`ifdef NLC_SCHED_STATS_EN
  logic [NCH*16-1:0] stat_done_cnt, stat_drop_cnt, g_stat_done_cnt, g_stat_drop_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  nlc_channel_scheduler #(.NUM_CH(NCH), .DATA_W(DW), .TAG_DEPTH(8), .ISSUE_GAP(1)) dut (
    .clk(clk), .GlobalReset(GlobalReset),
    .ch_srdyi(ch_srdyi), .ch_x_adc(ch_x_adc), .ch_srdyo(ch_srdyo), .ch_x_lin(ch_x_lin),
    .core_srdyi(core_srdyi), .core_x_adc(core_x_adc), .core_srdyo(core_srdyo),
    .core_x_lin(core_x_lin), .ovf_sticky(ovf_sticky), .orphan_sticky(orphan_sticky),
`ifdef NLC_SCHED_STATS_EN
    .stat_done_cnt(stat_done_cnt), .stat_drop_cnt(stat_drop_cnt),
`endif
    .in_flight(in_flight)
  );

  nlc_channel_scheduler #(.NUM_CH(NCH), .DATA_W(DW), .TAG_DEPTH(8), .ISSUE_GAP(3)) dut_g3 (
    .clk(clk), .GlobalReset(GlobalReset),
    .ch_srdyi(g_ch_srdyi), .ch_x_adc(g_ch_x_adc), .ch_srdyo(g_ch_srdyo), .ch_x_lin(g_ch_x_lin),
    .core_srdyi(g_core_srdyi), .core_x_adc(g_core_x_adc), .core_srdyo(g_core_srdyo),
    .core_x_lin(g_core_x_lin), .ovf_sticky(g_ovf_sticky), .orphan_sticky(g_orphan_sticky),
`ifdef NLC_SCHED_STATS_EN
    .stat_done_cnt(g_stat_done_cnt), .stat_drop_cnt(g_stat_drop_cnt),
`endif
    .in_flight(g_in_flight)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [DW-1:0] v);
    ch_x_adc[i*DW +: DW] = v;
  endtask

  task automatic do_reset;
    ch_srdyi = '0; ch_x_adc = '0; core_srdyo = 1'b0; core_x_lin = '0;
    g_ch_srdyi = '0; g_ch_x_adc = '0; g_core_srdyo = 1'b0; g_core_x_lin = '0;
    GlobalReset = 1'b1;
    tick; tick;
    GlobalReset = 1'b0;
  endtask

  // Two rounds of all-channel strobes with no core responses: 8 tags in flight.
  task automatic fill8(output int issues);
    issues = 0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < NCH; c++) set_ch(c, DW'(16 * r + c + 16));
      ch_srdyi = 4'hF; tick; ch_srdyi = '0;
      for (int k = 0; k < 5; k++) begin
        tick;
        if (core_srdyi === 1'b1) issues++;
      end
    end
  endtask

  task automatic test_reset;
    ch_srdyi = '0; ch_x_adc = '0; core_srdyo = 1'b0; core_x_lin = '0;
    g_ch_srdyi = '0; g_ch_x_adc = '0; g_core_srdyo = 1'b0; g_core_x_lin = '0;
    GlobalReset = 1'b1;
    tick; tick;
    n_vec++; if (core_srdyi !== 1'b0) begin n_err++; $display("FAIL reset_core_srdyi got %b want 0", core_srdyi); end
    n_vec++; if (core_x_adc !== '0) begin n_err++; $display("FAIL reset_core_x_adc got %h want 0", core_x_adc); end
    n_vec++; if (ch_srdyo !== '0) begin n_err++; $display("FAIL reset_ch_srdyo got %b want 0", ch_srdyo); end
    n_vec++; if (ch_x_lin !== '0) begin n_err++; $display("FAIL reset_ch_x_lin got %h want 0", ch_x_lin); end
    GlobalReset = 1'b0;
    tick;
    n_vec++; if (ovf_sticky !== '0) begin n_err++; $display("FAIL reset_ovf got %b want 0", ovf_sticky); end
    n_vec++; if (orphan_sticky !== 1'b0) begin n_err++; $display("FAIL reset_orphan got %b want 0", orphan_sticky); end
    n_vec++; if (in_flight !== 4'd0) begin n_err++; $display("FAIL reset_in_flight got %0d want 0", in_flight); end
  endtask

  task automatic test_single;
    do_reset;
    set_ch(2, 21'h0ABCD);
    ch_srdyi = 4'b0100; tick; ch_srdyi = '0;
    n_vec++; if (core_srdyi !== 1'b0) begin n_err++; $display("FAIL single_early got %b want 0", core_srdyi); end
    tick;
    n_vec++; if (core_srdyi !== 1'b1) begin n_err++; $display("FAIL single_issue got %b want 1", core_srdyi); end
    n_vec++; if (core_x_adc !== 21'h0ABCD) begin n_err++; $display("FAIL single_x_adc got %h want 0abcd", core_x_adc); end
    for (int k = 0; k < 4; k++) tick;
    core_srdyo = 1'b1; core_x_lin = 21'h0ABCD; tick; core_srdyo = 1'b0;
    n_vec++; if (ch_srdyo !== 4'b0100) begin n_err++; $display("FAIL single_srdyo got %b want 0100", ch_srdyo); end
    n_vec++; if (ch_x_lin !== 21'h0ABCD) begin n_err++; $display("FAIL single_x_lin got %h want 0abcd", ch_x_lin); end
    n_vec++; if (in_flight !== 4'd0) begin n_err++; $display("FAIL single_in_flight got %0d want 0", in_flight); end
    tick;
    n_vec++; if (ch_srdyo !== 4'b0000) begin n_err++; $display("FAIL single_srdyo_end got %b want 0000", ch_srdyo); end
  endtask

  task automatic test_fairness;
    logic [3:0] exp_oh;
    do_reset;
    for (int c = 0; c < NCH; c++) set_ch(c, DW'(32'h100 + c));
    ch_srdyi = 4'hF; tick; ch_srdyi = '0;
    tick;
    for (int k = 0; k < NCH; k++) begin
      n_vec++; if (core_srdyi !== 1'b1) begin n_err++; $display("FAIL fair_issue%0d got %b want 1", k, core_srdyi); end
      n_vec++; if (core_x_adc !== DW'(32'h100 + k)) begin n_err++; $display("FAIL fair_x_adc%0d got %h want %h", k, core_x_adc, 32'h100 + k); end
      tick;
    end
    n_vec++; if (core_srdyi !== 1'b0) begin n_err++; $display("FAIL fair_idle got %b want 0", core_srdyi); end
    n_vec++; if (in_flight !== 4'd4) begin n_err++; $display("FAIL fair_in_flight got %0d want 4", in_flight); end
    for (int k = 0; k < NCH; k++) begin
      core_srdyo = 1'b1; core_x_lin = DW'(32'h200 + k); tick;
      exp_oh = 4'b0001 << k;
      n_vec++; if (ch_srdyo !== exp_oh) begin n_err++; $display("FAIL fair_srdyo%0d got %b want %b", k, ch_srdyo, exp_oh); end
      n_vec++; if (ch_x_lin !== DW'(32'h200 + k)) begin n_err++; $display("FAIL fair_x_lin%0d got %h want %h", k, ch_x_lin, 32'h200 + k); end
    end
    core_srdyo = 1'b0; tick;
    n_vec++; if (in_flight !== 4'd0) begin n_err++; $display("FAIL fair_drain got %0d want 0", in_flight); end
  endtask

  task automatic test_capture_during_issue;
    do_reset;
    set_ch(1, 21'h11); ch_srdyi = 4'b0010; tick;
    set_ch(1, 21'h22); tick; ch_srdyi = '0;
    n_vec++; if (core_x_adc !== 21'h11) begin n_err++; $display("FAIL cdi_old got %h want 11", core_x_adc); end
    n_vec++; if (ovf_sticky !== 4'b0000) begin n_err++; $display("FAIL cdi_ovf got %b want 0000", ovf_sticky); end
    tick;
    n_vec++; if (core_srdyi !== 1'b1) begin n_err++; $display("FAIL cdi_reissue got %b want 1", core_srdyi); end
    n_vec++; if (core_x_adc !== 21'h22) begin n_err++; $display("FAIL cdi_new got %h want 22", core_x_adc); end
  endtask

  task automatic test_overflow;
    int iss;
    do_reset;
    fill8(iss);
    set_ch(1, 21'd5); ch_srdyi = 4'b0010; tick;
    n_vec++; if (ovf_sticky !== 4'b0000) begin n_err++; $display("FAIL ovf_first got %b want 0000", ovf_sticky); end
    set_ch(1, 21'd7); tick; ch_srdyi = '0;
    n_vec++; if (ovf_sticky !== 4'b0010) begin n_err++; $display("FAIL ovf_set got %b want 0010", ovf_sticky); end
`ifdef NLC_SCHED_STATS_EN
    n_vec++; if (stat_drop_cnt[16 +: 16] !== 16'd1) begin n_err++; $display("FAIL ovf_drop_cnt got %0d want 1", stat_drop_cnt[16 +: 16]); end
`endif
    tick;
    n_vec++; if (core_srdyi !== 1'b0) begin n_err++; $display("FAIL ovf_blocked got %b want 0", core_srdyi); end
    core_srdyo = 1'b1; core_x_lin = 21'h33; tick; core_srdyo = 1'b0;
    n_vec++; if (core_srdyi !== 1'b1 || core_x_adc !== 21'd7) begin n_err++; $display("FAIL ovf_issue got %b/%h want 1/7", core_srdyi, core_x_adc); end
    n_vec++; if (ch_srdyo !== 4'b0001) begin n_err++; $display("FAIL ovf_ret got %b want 0001", ch_srdyo); end
  endtask

  task automatic test_full_fifo;
    int iss;
    do_reset;
    fill8(iss);
    set_ch(2, 21'h999); ch_srdyi = 4'b0100; tick; ch_srdyi = '0;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (core_srdyi === 1'b1) iss++;
    end
    n_vec++; if (iss !== 8) begin n_err++; $display("FAIL full_issues got %0d want 8", iss); end
    n_vec++; if (in_flight !== 4'd8) begin n_err++; $display("FAIL full_in_flight got %0d want 8", in_flight); end
    core_srdyo = 1'b1; core_x_lin = 21'h77; tick; core_srdyo = 1'b0;
    n_vec++; if (core_srdyi !== 1'b1 || core_x_adc !== 21'h999) begin n_err++; $display("FAIL full_ninth got %b/%h want 1/999", core_srdyi, core_x_adc); end
    n_vec++; if (ch_srdyo !== 4'b0001 || ch_x_lin !== 21'h77) begin n_err++; $display("FAIL full_pop got %b/%h want 0001/77", ch_srdyo, ch_x_lin); end
    n_vec++; if (in_flight !== 4'd8) begin n_err++; $display("FAIL full_pushpop got %0d want 8", in_flight); end
  endtask

  task automatic test_orphan_reset;
    do_reset;
    core_srdyo = 1'b1; core_x_lin = 21'h55; tick; core_srdyo = 1'b0;
    n_vec++; if (orphan_sticky !== 1'b1) begin n_err++; $display("FAIL orphan_set got %b want 1", orphan_sticky); end
    n_vec++; if (ch_srdyo !== 4'b0000 || ch_x_lin !== '0) begin n_err++; $display("FAIL orphan_out got %b/%h want 0000/0", ch_srdyo, ch_x_lin); end
    n_vec++; if (in_flight !== 4'd0) begin n_err++; $display("FAIL orphan_empty got %0d want 0", in_flight); end
    for (int c = 0; c < 3; c++) set_ch(c, DW'(c + 1));
    ch_srdyi = 4'b0111; tick; ch_srdyi = '0;
    for (int k = 0; k < 4; k++) tick;
    n_vec++; if (in_flight !== 4'd3) begin n_err++; $display("FAIL rst_pre got %0d want 3", in_flight); end
    GlobalReset = 1'b1; tick; GlobalReset = 1'b0;
    n_vec++; if (in_flight !== 4'd0 || orphan_sticky !== 1'b0) begin n_err++; $display("FAIL rst_mid got %0d/%b want 0/0", in_flight, orphan_sticky); end
    n_vec++; if (core_srdyi !== 1'b0 || core_x_adc !== '0 || ch_srdyo !== '0 || ch_x_lin !== '0 || ovf_sticky !== '0) begin
      n_err++; $display("FAIL rst_outputs got %b/%h/%b/%h/%b want all 0", core_srdyi, core_x_adc, ch_srdyo, ch_x_lin, ovf_sticky);
    end
    core_srdyo = 1'b1; core_x_lin = 21'h66; tick; core_srdyo = 1'b0;
    n_vec++; if (orphan_sticky !== 1'b1 || ch_srdyo !== 4'b0000) begin n_err++; $display("FAIL rst_orphan got %b/%b want 1/0000", orphan_sticky, ch_srdyo); end
  endtask

  task automatic test_gap;
    int npulse;
    logic exp_p;
    logic [DW-1:0] exp_v;
    do_reset;
    npulse = 0;
    for (int t = 1; t <= 20; t++) begin
      g_ch_x_adc[0*DW +: DW] = DW'(32'h1000 + t);
      g_ch_x_adc[3*DW +: DW] = DW'(32'h3000 + t);
      g_ch_srdyi = 4'b1001;
      tick;
      exp_p = (t >= 2) && (((t - 2) % 3) == 0);
      n_vec++; if (g_core_srdyi !== exp_p) begin n_err++; $display("FAIL gap_pulse_t%0d got %b want %b", t, g_core_srdyi, exp_p); end
      if (exp_p) begin
        exp_v = ((((t - 2) / 3) % 2) == 0) ? DW'(32'h1000 + t - 1) : DW'(32'h3000 + t - 1);
        n_vec++; if (g_core_x_adc !== exp_v) begin n_err++; $display("FAIL gap_data_t%0d got %h want %h", t, g_core_x_adc, exp_v); end
      end
      if (g_core_srdyi === 1'b1) npulse++;
    end
    g_ch_srdyi = '0;
    n_vec++; if (npulse !== 7 || g_in_flight !== 4'd7) begin n_err++; $display("FAIL gap_count got %0d/%0d want 7/7", npulse, g_in_flight); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_capture_during_issue;
    test_overflow;
    test_full_fifo;
    test_orphan_reset;
    test_gap;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
